mul_frac_arbiter: RTL

//  Shares one pipelined signed fixed-point Booth/Wallace multiplier between NUM_REQ requesters.

---
 rtl/mul_frac_pkg.sv | 35 +++
 rtl/mul_frac_arbiter_if.sv | 26 ++
 rtl/mul_frac_arbiter_mul.sv | 74 +++++++
 rtl/mul_frac_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mul_frac_pkg.sv
// Shared types and result formatting for the fractional multiplier family.
// Kept width-generic so MAC blocks can reuse sat_trunc with their own Q format.
package mul_frac_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAINING = 2'd1,
    DRAINED  = 2'd2
  } arb_state_t;

  // Widest result the formatter supports; callers take the low w bits of data.
  localparam int SAT_MAXW = 64;

  typedef struct packed {
    logic                sat;
    logic [SAT_MAXW-1:0] data;
  } sat_res_t;

  // Truncates a sign-extended product toward -inf to Q(w-frac).frac and saturates.
  // Overflow means the bits from the result sign position upward are not all equal.
  function automatic sat_res_t sat_trunc(input logic signed [2*SAT_MAXW-1:0] p,
                                         input int w,
                                         input int frac);
    logic signed [2*SAT_MAXW-1:0] hi;
    logic [SAT_MAXW-1:0]          max_pos;
    sat_res_t                     res;
    hi      = p >>> (w + frac - 1);
    max_pos = {SAT_MAXW{1'b1}} >> (SAT_MAXW - w + 1);
    res.sat = !((hi == '0) || (hi == '1));
    if (res.sat) res.data = p[2*SAT_MAXW-1] ? ~max_pos : max_pos;
    else         res.data = SAT_MAXW'(p >>> frac);
    return res;
  endfunction

endpackage

// File: rtl/mul_frac_arbiter_if.sv
// Request/response bundle between the requesters and the shared multiplier arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface mul_frac_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 16,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_data;
  logic                 rsp_sat;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat
  );
endinterface

// File: rtl/mul_frac_arbiter_mul.sv
// Two-stage signed radix-4 Booth multiplier with carry-save partial-product reduction.
// Stage 1 registers the reduced sum/carry pair, stage 2 registers the final product.
module booth_wallace_mul_frac #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0]       a,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0]       b,
  output logic [2*(INT_WIDTH+FRAC_WIDTH)-1:0]   p
);
  localparam int WIDTH = INT_WIDTH + FRAC_WIDTH;
  localparam int PW    = 2 * WIDTH;
  localparam int NPP   = (WIDTH + 1) / 2;

  logic signed [PW-1:0]  a_ext;
  logic signed [2*NPP:0] b_ext;
  logic [PW-1:0]         pp [NPP];
  logic [PW-1:0]         booth_mag;
  logic [PW-1:0]         cs_sum;
  logic [PW-1:0]         cs_carry;
  logic [PW-1:0]         csa_s;
  logic [PW-1:0]         csa_c;
  logic [PW-1:0]         sum_q;
  logic [PW-1:0]         carry_q;

  // b gets an implicit 0 below the LSB so every digit sees a 3-bit overlapping window.
  assign a_ext = PW'($signed(a));
  assign b_ext = (2*NPP+1)'($signed({b, 1'b0}));

  // NOTE: every variable here gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    booth_mag = '0;
    for (int i = 0; i < NPP; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: booth_mag = a_ext;
        3'b011:         booth_mag = a_ext <<< 1;
        3'b100:         booth_mag = -(a_ext <<< 1);
        3'b101, 3'b110: booth_mag = -a_ext;
        default:        booth_mag = '0;
      endcase
      pp[i] = booth_mag << (2 * i);
    end
  end

  // 3:2 compression keeps everything modulo 2^PW, which is exact for a signed WIDTH x WIDTH product.
  always_comb begin
    cs_sum   = pp[0];
    cs_carry = '0;
    csa_s    = '0;
    csa_c    = '0;
    for (int i = 1; i < NPP; i++) begin
      csa_s    = cs_sum ^ cs_carry ^ pp[i];
      csa_c    = ((cs_sum & cs_carry) | (cs_sum & pp[i]) | (cs_carry & pp[i])) << 1;
      cs_sum   = csa_s;
      cs_carry = csa_c;
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      p       <= '0;
    end else begin
      sum_q   <= cs_sum;
      carry_q <= cs_carry;
      p       <= sum_q + carry_q;
    end
  end

endmodule

// File: rtl/mul_frac_arbiter.sv
// Round-robin arbiter sharing one pipelined Q(INT.FRAC) multiplier between NUM_REQ requesters,
// with in-flight id tracking, truncate/saturate formatting and a drain handshake.
module mul_frac_arbiter
  import mul_frac_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int MUL_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  mul_frac_arbiter_if.slave  bus,
  input  logic               drain,
  output logic               drain_done,
  output logic               busy,
  output logic [31:0]        issue_cnt
);
  localparam int W   = INT_WIDTH + FRAC_WIDTH;
  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_DRAINING = DRAINING;
  localparam logic [1:0] ST_DRAINED  = DRAINED;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic             grant_en;
  logic             handshake;
  logic [IDW:0]     cand_sum;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   last_sel;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   prod;
  logic signed [2*W-1:0] prod_s;
  sat_res_t         fmt;
  logic             unused_fmt_hi;
  logic [MUL_LAT-1:0] vld_sr;
  logic [IDW-1:0]   id_sr [MUL_LAT];

  // Arbitration: first valid index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      cand = cand_sum[IDW-1:0];
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A rising drain suppresses the grant in the same cycle it is seen.
  assign grant_en  = (state == ST_RUN) && !drain;
  assign handshake = grant_en && grant_found;

  always_comb begin
    bus.req_ready = '0;
    if (handshake) bus.req_ready[grant_idx] = 1'b1;
  end

  // Idle cycles keep the previous requester selected so the multiplier inputs do not toggle needlessly.
  assign sel   = handshake ? grant_idx : last_sel;
  assign mul_a = bus.req_a[sel*W +: W];
  assign mul_b = bus.req_b[sel*W +: W];

  booth_wallace_mul_frac #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod)
  );

  assign prod_s        = prod;
  assign fmt           = sat_trunc((2*SAT_MAXW)'(prod_s), W, FRAC_WIDTH);
  assign unused_fmt_hi = ^fmt.data[SAT_MAXW-1:W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      last_sel  <= '0;
      issue_cnt <= '0;
    end else if (handshake) begin
      ptr       <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      last_sel  <= grant_idx;
      issue_cnt <= issue_cnt + 32'd1;
    end
  end

  // The id pipe mirrors the multiplier depth, so its tail lines up with the product.
  // NOTE: this pipe is a handful of flops and must be flushed on reset; a real RAM would not be reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      for (int i = 0; i < MUL_LAT; i++) id_sr[i] <= '0;
    end else begin
      vld_sr[0] <= handshake;
      id_sr[0]  <= grant_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  assign busy = |vld_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_sat   <= 1'b0;
    end else begin
      bus.rsp_valid <= vld_sr[MUL_LAT-1];
      if (vld_sr[MUL_LAT-1]) begin
        bus.rsp_id   <= id_sr[MUL_LAT-1];
        bus.rsp_data <= fmt.data[W-1:0];
        bus.rsp_sat  <= fmt.sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:      if (drain) state <= ST_DRAINING;
        ST_DRAINING: if (!busy) state <= ST_DRAINED;
        ST_DRAINED:  if (!drain) state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

  assign drain_done = (state == ST_DRAINED);

endmodule
